uart_crc_transmitter: RTL and testbench
=======================================

# uart_crc_transmitter

Upstream partner of the CRC-8 UART receiver. The block accepts one data byte per valid/ready handshake and computes its CRC-8 bit-serially. It then serializes an 18-bit frame onto `tx_out` at the receiver's exact bit period, LSB first: start(0), 8 data bits, 8 CRC bits, stop(1). It sits between the host/test logic and the serial line feeding the receiver.

## Interface
Parameters:
- `BAUD_RATE`, 9600: line rate.
- `CLK_FREQ`, 50000000: system clock frequency, Hz.
- `OVERSAMPLING_RATE`, 16: must match the receiver.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-low reset (sampled on `clk` rising edge; 0 = reset).
- `tx_data`  in  8  byte to send; must be stable while `tx_valid`=1 and not yet accepted.
- `tx_valid`  in  1  request to send `tx_data`.
- `tx_ready`  out  1  high only in IDLE; a transfer occurs on the edge where `tx_valid && tx_ready`.
- `tx_out`  out  1  serial line; idles high.
- `tx_busy`  out  1  high in every state except IDLE.
- `crc_out`  out  8  CRC of the byte in flight; holds the last value after the frame ends.
- `tx_done`  out  1  one-cycle pulse when the stop bit completes.

## Operation
- Derived constants:
  - `BAUD_DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLING_RATE)`, integer division.
  - `CLKS_PER_BIT = BAUD_DIV*OVERSAMPLING_RATE` (5200 at defaults). This is identical to the receiver's bit period; using `CLK_FREQ/BAUD_RATE` is forbidden.
- CRC-8 definition:
  - Polynomial 0x07 (x^8+x^2+x+1), init 0x00, MSB-first, no reflection, no final XOR.
  - Bit-serial: `crc = {crc[6:0],1'b0} ^ (crc[7]^d ? 8'h07 : 0)`, consuming `d` = data[7] down to data[0].
- FSM states: IDLE, CRC_CALC, START, DATA, CRC_BITS, STOP.
  - IDLE: `tx_out`=1, `tx_ready`=1. On handshake, latch `tx_data`, clear the crc register and bit index, then go to CRC_CALC.
  - CRC_CALC: exactly 8 cycles, one data bit per cycle, then go to START. `crc_out` shows the running value.
  - START: `tx_out`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: 8 bits; data[i] is driven for `CLKS_PER_BIT` cycles each, i = 0..7. Then go to CRC_BITS.
  - CRC_BITS: 8 bits; crc[i] for i = 0..7. Then go to STOP.
  - STOP: `tx_out`=1 for `CLKS_PER_BIT` cycles. Pulse `tx_done`, then go to IDLE.
- Counter widths: the bit-time counter is `$clog2(CLKS_PER_BIT)` bits; the bit index is 3 bits and wraps 7→0 on each state change.
- `tx_out`, `tx_ready` and `tx_busy` are registered outputs, not decoded combinationally from next-state.

## Timing
- Reset values:
  - `tx_out`=1, `tx_ready`=1 (IDLE), `tx_busy`=0.
  - `crc_out`=0x00, `tx_done`=0, state IDLE.
- Reset mid-frame: the next edge forces the reset values and `tx_out`=1. The partial frame is abandoned without a stop bit; the downstream receiver tolerates this.
- Acceptance at edge T:
  - `tx_ready` falls after T.
  - CRC_CALC occupies edges T+1..T+8.
  - `tx_out` falls after edge T+8.
- Frame length on the line is 18×`CLKS_PER_BIT` cycles. `tx_done` is high for exactly the one cycle in which the state returns to IDLE. `tx_ready` is high in that same cycle.
- Back-to-back: `tx_valid` held high re-accepts on the first IDLE cycle, so the minimum gap between frames is 1 clk of idle-high plus 8 clk of CRC_CALC.
- `tx_valid` while busy is ignored; no queuing.
- `tx_data` changes after acceptance do not affect the frame in flight.

## Structure
- Shared package `uart_crc_pkg` holds:
  - `CLK_FREQ`, `OVERSAMPLING_RATE`, `FRAME_BITS`=18;
  - `CRC8_POLY`=8'h07, `CRC8_INIT`=8'h00;
  - the FSM state enum.
- One sub-module, `crc8_serial`: ports `clk`, `reset`, `clr`, `en`, `din`, `crc[7:0]`; one bit per enabled cycle. The receiver-side checker will reuse it.

## Test plan
Shrink timing for simulation: `CLK_FREQ`=1600000, `BAUD_RATE`=100000, giving `CLKS_PER_BIT`=16.
- Byte 0x31 → `crc_out`=0x97. Line shows 0, 1000 1100, 1110 1001, 1 (LSB first), each bit 16 clk. `tx_done` pulses 8+288 clk after acceptance.
- Bytes 0x00, 0x01, 0xFF → CRCs 0x00, 0x07, 0xF3. Loopback into the CRC-8 receiver yields matching `data_out`/`crc_out` with `rx_ready`.
- `tx_valid` held high with 0xA5 then 0x3C → two frames separated by exactly 9 idle/CRC cycles of `tx_out`=1. Second CRC correct.
- `tx_valid` pulsed during DATA of frame 1 → ignored. `tx_ready`=0 throughout; only one frame is sent.
- Reset driven low in the middle of CRC_BITS → next cycle `tx_out`=1, `tx_busy`=0, `crc_out`=0x00. A new byte sent afterwards frames correctly.
- `tx_data` changed the cycle after acceptance → transmitted data and CRC reflect the latched byte only.

Source files
------------

// File: rtl/uart_crc_pkg.sv
// -----------------------------------------------------------------------------
// uart_crc_pkg
// Shared definitions for the CRC-8 UART transmitter/receiver pair: default
// clock and oversampling figures, frame length, CRC-8 polynomial and seed,
// the transmitter FSM state type and a one-bit CRC update helper.
// -----------------------------------------------------------------------------
package uart_crc_pkg;

  localparam int CLK_FREQ          = 50_000_000;
  localparam int OVERSAMPLING_RATE = 16;
  localparam int FRAME_BITS        = 18;  // start + 8 data + 8 crc + stop

  localparam logic [7:0] CRC8_POLY = 8'h07;  // x^8 + x^2 + x + 1
  localparam logic [7:0] CRC8_INIT = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRC_CALC,
    ST_START,
    ST_DATA,
    ST_CRC_BITS,
    ST_STOP
  } tx_state_e;

  // One MSB-first step: shift left and fold in the polynomial when the bit
  // falling out of the register differs from the incoming data bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic d);
    crc8_step = {crc[6:0], 1'b0} ^ ((crc[7] ^ d) ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/uart_crc_transmitter_if.sv
// -----------------------------------------------------------------------------
// uart_crc_transmitter_if
// Host-side bundle of the CRC-8 UART transmitter.
//   tx_data  [7:0]  byte to send (host -> transmitter)
//   tx_valid        send request (host -> transmitter)
//   tx_ready        transmitter idle, will accept (transmitter -> host)
//   tx_out          serial line, idles high (transmitter -> line)
//   tx_busy         frame in progress
//   crc_out  [7:0]  CRC of the byte in flight / last byte sent
//   tx_done         one-cycle pulse at end of the stop bit
// master = host, slave = transmitter.
// -----------------------------------------------------------------------------
interface uart_crc_transmitter_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_out;
  logic       tx_busy;
  logic [7:0] crc_out;
  logic       tx_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_out, tx_busy, crc_out, tx_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_out, tx_busy, crc_out, tx_done
  );

endinterface

// File: rtl/crc8_serial.sv
// -----------------------------------------------------------------------------
// crc8_serial
// Bit-serial CRC-8 (poly 0x07, seed 0x00, MSB first, no reflection, no final
// XOR). Consumes one bit per cycle while en is high.
//   clk        system clock
//   reset      synchronous active-low reset
//   clr        reload the seed (wins over en)
//   en         consume din this cycle
//   din        next message bit, most significant first
//   crc  [7:0] running CRC register
// -----------------------------------------------------------------------------
module crc8_serial
  import uart_crc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      crc <= CRC8_INIT;
    end else if (clr) begin
      crc <= CRC8_INIT;
    end else if (en) begin
      crc <= crc8_step(crc, din);
    end
  end

endmodule

// File: rtl/uart_crc_transmitter.sv
// -----------------------------------------------------------------------------
// uart_crc_transmitter
// Accepts a byte on a valid/ready handshake, computes its CRC-8 over 8 cycles,
// then sends start(0), 8 data bits, 8 CRC bits and stop(1), all LSB first, at
// the receiver's bit period BAUD_DIV*OVERSAMPLING_RATE clocks.
//   clk    system clock
//   reset  synchronous active-low reset
//   bus    slave side of uart_crc_transmitter_if (handshake, line, status)
// -----------------------------------------------------------------------------
module uart_crc_transmitter #(
  parameter int BAUD_RATE         = 9600,
  parameter int CLK_FREQ          = uart_crc_pkg::CLK_FREQ,
  parameter int OVERSAMPLING_RATE = uart_crc_pkg::OVERSAMPLING_RATE
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_crc_transmitter_if.slave  bus
);

  import uart_crc_pkg::*;

  // The bit period is derived exactly as the receiver derives it (truncated
  // oversample divider times the oversampling rate), so both ends agree even
  // when CLK_FREQ is not an exact multiple of the line rate.
  localparam int BAUD_DIV     = CLK_FREQ / (BAUD_RATE * OVERSAMPLING_RATE);
  localparam int CLKS_PER_BIT = BAUD_DIV * OVERSAMPLING_RATE;
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q;
  logic [7:0]    data_q;
  logic [2:0]    bit_idx_q;
  logic [CW-1:0] cnt_q;
  logic          tx_out_q;
  logic          tx_ready_q;
  logic          tx_busy_q;
  logic          tx_done_q;

  logic          accept;
  logic          bit_end;
  logic          crc_clr;
  logic          crc_en;
  logic          crc_din;
  logic [7:0]    crc_w;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    accept  = (state_q == ST_IDLE) && tx_ready_q && bus.tx_valid;
    bit_end = (cnt_q == CNT_LAST);
    crc_clr = accept;
    crc_en  = (state_q == ST_CRC_CALC);
    // CRC consumes the latched byte MSB first while bit_idx counts up.
    crc_din = data_q[3'd7 - bit_idx_q];
  end

  crc8_serial u_crc (
    .clk   (clk),
    .reset (reset),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (crc_din),
    .crc   (crc_w)
  );

  // Each state loads the line value of the *next* bit on its final cycle, so
  // tx_out is a plain flop and changes exactly on bit boundaries.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      bit_idx_q  <= '0;
      cnt_q      <= '0;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            data_q     <= bus.tx_data;
            bit_idx_q  <= '0;
            cnt_q      <= '0;
            tx_ready_q <= 1'b0;
            tx_busy_q  <= 1'b1;
            state_q    <= ST_CRC_CALC;
          end
        end
        ST_CRC_CALC: begin
          // bit_idx wraps 7 -> 0 on the way into START.
          bit_idx_q <= bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            tx_out_q <= 1'b0;
            state_q  <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            cnt_q    <= '0;
            tx_out_q <= data_q[0];
            state_q  <= ST_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt_q     <= '0;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              tx_out_q <= crc_w[0];
              state_q  <= ST_CRC_BITS;
            end else begin
              tx_out_q <= data_q[bit_idx_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_CRC_BITS: begin
          if (bit_end) begin
            cnt_q     <= '0;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              tx_out_q <= 1'b1;
              state_q  <= ST_STOP;
            end else begin
              tx_out_q <= crc_w[bit_idx_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            cnt_q      <= '0;
            tx_done_q  <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
            state_q    <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_out   = tx_out_q;
  assign bus.tx_ready = tx_ready_q;
  assign bus.tx_busy  = tx_busy_q;
  assign bus.tx_done  = tx_done_q;
  assign bus.crc_out  = crc_w;

endmodule

// File: tb/tb_uart_crc_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_crc_transmitter
// Directed bench for uart_crc_transmitter with CLKS_PER_BIT = 16. Inputs are
// driven and outputs sampled on the falling clock edge. Sample index k counts
// falling edges after the accepting rising edge T (k = 0 just after T).
// -----------------------------------------------------------------------------
module tb_uart_crc_transmitter;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  uart_crc_transmitter_if bus ();

  uart_crc_transmitter #(
    .BAUD_RATE         (100_000),
    .CLK_FREQ          (1_600_000),
    .OVERSAMPLING_RATE (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a byte and wait (bounded) for the accepting edge; returns on the
  // falling edge just after it (k = 0).
  task automatic accept(input string tag, input logic [7:0] d, input logic hold);
    int n;
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    n = 0;
    while (bus.tx_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".ready_timeout"}, (n < 1000) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    if (!hold) bus.tx_valid = 1'b0;
    check({tag, ".ready_fall"}, 32'(bus.tx_ready), 32'd0);
    check({tag, ".busy_rise"},  32'(bus.tx_busy),  32'd1);
  endtask

  // Walk the whole frame cycle by cycle from k = 0 to k = 296 (the cycle in
  // which tx_done should be high). Optionally poke the inputs at k = poke_k.
  task automatic check_frame(input string tag, input logic [7:0] d, input logic [7:0] c,
                             input int poke_k, input logic [7:0] poke_data,
                             input logic poke_valid);
    int         line_err  = 0;
    int         ready_err = 0;
    int         done_n    = 0;
    int         done_k    = -1;
    logic [7:0] od        = '0;
    logic [7:0] oc        = '0;
    logic       exp_bit;
    for (int k = 0; k <= 296; k++) begin
      if (k < 8)        exp_bit = 1'b1;            // CRC_CALC, line idle
      else if (k < 24)  exp_bit = 1'b0;            // start bit
      else if (k < 152) exp_bit = d[(k - 24) / 16];
      else if (k < 280) exp_bit = c[(k - 152) / 16];
      else              exp_bit = 1'b1;            // stop bit, then idle
      if (bus.tx_out !== exp_bit) line_err++;
      if (k >= 24 && k < 152 && (k - 24) % 16 == 8)   od[(k - 24) / 16]  = bus.tx_out;
      if (k >= 152 && k < 280 && (k - 152) % 16 == 8) oc[(k - 152) / 16] = bus.tx_out;
      if (bus.tx_done === 1'b1) begin
        done_n++;
        done_k = k;
      end
      if (k < 296 && bus.tx_ready !== 1'b0) ready_err++;
      if (k == poke_k) begin
        bus.tx_data = poke_data;
        if (poke_valid) bus.tx_valid = 1'b1;
      end
      if (k == poke_k + 1 && poke_valid) bus.tx_valid = 1'b0;
      if (k < 296) @(negedge clk);
    end
    check({tag, ".line_cycles"}, 32'(line_err), 32'd0);
    check({tag, ".data_bits"},   32'(od),       32'(d));
    check({tag, ".crc_bits"},    32'(oc),       32'(c));
    check({tag, ".crc_out"},     32'(bus.crc_out), 32'(c));
    check({tag, ".done_cycle"},  32'(done_k),   32'd296);
    check({tag, ".done_count"},  32'(done_n),   32'd1);
    check({tag, ".ready_low"},   32'(ready_err), 32'd0);
    check({tag, ".ready_idle"},  32'(bus.tx_ready), 32'd1);
    check({tag, ".busy_idle"},   32'(bus.tx_busy),  32'd0);
  endtask

  initial begin
    int idle_err;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.tx_out",   32'(bus.tx_out),   32'd1);
    check("rst.tx_ready", 32'(bus.tx_ready), 32'd1);
    check("rst.tx_busy",  32'(bus.tx_busy),  32'd0);
    check("rst.crc_out",  32'(bus.crc_out),  32'h00);
    check("rst.tx_done",  32'(bus.tx_done),  32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 0x31 -> CRC 0x97
    accept("b31", 8'h31, 1'b0);
    check_frame("b31", 8'h31, 8'h97, -1, 8'h00, 1'b0);

    // Edge bytes
    accept("b00", 8'h00, 1'b0);
    check_frame("b00", 8'h00, 8'h00, -1, 8'h00, 1'b0);
    accept("bff", 8'hFF, 1'b0);
    check_frame("bff", 8'hFF, 8'hF3, -1, 8'h00, 1'b0);

    // tx_data changed right after acceptance: frame uses the latched 0x01
    accept("chg", 8'h01, 1'b0);
    check_frame("chg", 8'h01, 8'h07, 0, 8'hFF, 1'b0);

    // tx_valid pulsed during DATA: ignored, exactly one frame
    bus.tx_data = 8'h00;
    accept("ign", 8'h00, 1'b0);
    check_frame("ign", 8'h00, 8'h00, 50, 8'h55, 1'b1);
    idle_err = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.tx_out !== 1'b1 || bus.tx_busy !== 1'b0) idle_err++;
    end
    check("ign.no_second_frame", 32'(idle_err), 32'd0);

    // Back-to-back with tx_valid held: 0xA5 -> 0x72, then 0x3C -> 0xB4.
    // The second acceptance lands on the idle cycle (k = 296 -> next edge).
    accept("b2b1", 8'hA5, 1'b1);
    check_frame("b2b1", 8'hA5, 8'h72, 10, 8'h3C, 1'b0);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    check("b2b2.ready_fall", 32'(bus.tx_ready), 32'd0);
    check("b2b2.busy_rise",  32'(bus.tx_busy),  32'd1);
    check_frame("b2b2", 8'h3C, 8'hB4, -1, 8'h00, 1'b0);

    // Reset in the middle of CRC_BITS (k = 200)
    accept("rstmid", 8'hFF, 1'b0);
    repeat (200) @(negedge clk);
    check("rstmid.busy_before", 32'(bus.tx_busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("rstmid.tx_out",   32'(bus.tx_out),   32'd1);
    check("rstmid.tx_busy",  32'(bus.tx_busy),  32'd0);
    check("rstmid.crc_out",  32'(bus.crc_out),  32'h00);
    check("rstmid.tx_ready", 32'(bus.tx_ready), 32'd1);
    reset = 1'b1;
    accept("after_rst", 8'h31, 1'b0);
    check_frame("after_rst", 8'h31, 8'h97, -1, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
